toy_tage_tbl_arb: RTL and testbench

Single-port access controller for one TAGE predictor table. It shares the table's single memory port between two requesters:
- the fetch-side lookup (read) stream;
- the commit-side update stream. Each update performs a two-cycle read-modify-write of the entry's 2-bit saturating counter.

Updates are buffered in a small FIFO so commit is never stalled by lookup traffic. A starvation limit bounds how long lookups can delay buffered updates.

---
 rtl/toy_tage_tbl_arb.sv | 154 +++++++++++++++
 tb/tb_toy_tage_tbl_arb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/toy_tage_tbl_arb.sv
// toy_tage_tbl_arb: single-port access controller for one TAGE table.
// Fetch lookups and buffered commit updates share the table port. Each
// update is a two-cycle read-modify-write of the entry's 2-bit counter.
// A starvation counter bounds how long lookups can hold off queued updates.
module toy_tage_tbl_arb #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int UPD_DEPTH    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lkp_vld,
  output logic                  lkp_rdy,
  input  logic [ADDR_WIDTH-1:0] lkp_addr,
  output logic                  lkp_rsp_vld,
  output logic [DATA_WIDTH-1:0] lkp_rsp_data,
  input  logic                  upd_vld,
  output logic                  upd_rdy,
  input  logic [ADDR_WIDTH-1:0] upd_addr,
  input  logic                  upd_taken,
  output logic                  mem_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam int PTR_W = $clog2(UPD_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {S_IDLE, S_UPD_WR} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_fifo_addr [UPD_DEPTH];
  logic [UPD_DEPTH-1:0]  r_fifo_taken;
  logic [PTR_W-1:0]      r_wptr, r_rptr;
  logic [CNT_W-1:0]      r_cnt;
  logic [SC_W-1:0]       r_starve;
  logic                  r_rsp_vld;

  logic                  w_empty, w_full, w_push, w_pop, w_starve_ok;
  logic                  w_lkp_go, w_upd_go;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic                  w_head_taken;
  logic [1:0]            w_ctr, w_ctr_nxt;

  assign w_empty      = (r_cnt == '0);
  assign w_full       = (r_cnt == CNT_W'(UPD_DEPTH));
  assign w_push       = upd_vld && !w_full;
  assign w_pop        = (r_state == S_UPD_WR);
  assign w_starve_ok  = (r_starve < SC_W'(STARVE_LIMIT));
  assign w_head_addr  = r_fifo_addr[r_rptr];
  assign w_head_taken = r_fifo_taken[r_rptr];

  assign upd_rdy      = !w_full;
  assign lkp_rsp_vld  = r_rsp_vld;
  assign lkp_rsp_data = mem_rd_data;

  // Saturating counter step on the word read in the previous cycle
  assign w_ctr = mem_rd_data[1:0];
  always_comb begin
    w_ctr_nxt = w_ctr;
    if (w_head_taken) begin
      if (w_ctr != 2'd3) w_ctr_nxt = 2'(w_ctr + 2'd1);
    end else begin
      if (w_ctr != 2'd0) w_ctr_nxt = 2'(w_ctr - 2'd1);
    end
  end

  // Port arbitration and next state
  always_comb begin
    w_state_nxt = r_state;
    w_lkp_go    = 1'b0;
    w_upd_go    = 1'b0;
    lkp_rdy     = 1'b0;
    mem_en      = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    case (r_state)
      S_IDLE: begin
        lkp_rdy = w_empty || w_starve_ok;
        if (lkp_vld && (w_empty || w_starve_ok)) begin
          w_lkp_go = 1'b1;
          mem_en   = 1'b1;
          mem_addr = lkp_addr;
        end else if (!w_empty) begin
          w_upd_go    = 1'b1;
          lkp_rdy     = 1'b0;
          mem_en      = 1'b1;
          mem_addr    = w_head_addr;
          w_state_nxt = S_UPD_WR;
        end
      end
      S_UPD_WR: begin
        mem_en      = 1'b1;
        mem_wr_en   = 1'b1;
        mem_addr    = w_head_addr;
        mem_wr_data = {mem_rd_data[DATA_WIDTH-1:2], w_ctr_nxt};
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A reset edge must not commit an in-flight table access
    if (!rst_n) begin
      mem_en    = 1'b0;
      mem_wr_en = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Update FIFO: pointers and occupancy; push and pop may coincide
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= PTR_W'(r_wptr + 1'b1);
      if (w_pop)  r_rptr <= PTR_W'(r_rptr + 1'b1);
      if (w_push && !w_pop)      r_cnt <= CNT_W'(r_cnt + 1'b1);
      else if (w_pop && !w_push) r_cnt <= CNT_W'(r_cnt - 1'b1);
    end
  end

  // Update FIFO storage; contents need no reset, occupancy gates them
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr]  <= upd_addr;
      r_fifo_taken[r_wptr] <= upd_taken;
    end
  end

  // Starvation counter: lookups granted while updates wait
  always_ff @(posedge clk) begin
    if (!rst_n || w_empty)          r_starve <= '0;
    else if (w_upd_go)              r_starve <= '0;
    else if (w_lkp_go && w_starve_ok) r_starve <= SC_W'(r_starve + 1'b1);
  end

  // Lookup response valid, one cycle after acceptance
  always_ff @(posedge clk) begin
    if (!rst_n) r_rsp_vld <= 1'b0;
    else        r_rsp_vld <= w_lkp_go;
  end

endmodule

// File: tb/tb_toy_tage_tbl_arb.sv
// Directed bench for toy_tage_tbl_arb with a behavioural table model.
module tb_toy_tage_tbl_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lkp_vld, lkp_rdy, lkp_rsp_vld;
  logic [31:0] lkp_addr, lkp_rsp_data;
  logic        upd_vld, upd_rdy, upd_taken;
  logic [31:0] upd_addr;
  logic        mem_en, mem_wr_en;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] tbl [logic [31:0]];
  logic [31:0] wq_data [$];
  logic [31:0] wq_addr [$];

  always #5 clk = ~clk;

  toy_tage_tbl_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .UPD_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .lkp_vld(lkp_vld), .lkp_rdy(lkp_rdy), .lkp_addr(lkp_addr),
    .lkp_rsp_vld(lkp_rsp_vld), .lkp_rsp_data(lkp_rsp_data),
    .upd_vld(upd_vld), .upd_rdy(upd_rdy), .upd_addr(upd_addr), .upd_taken(upd_taken),
    .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  // Table model: unwritten entries read as 2; writes are logged in order
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr_en) begin
        tbl[mem_addr] = mem_wr_data;
        wq_data.push_back(mem_wr_data);
        wq_addr.push_back(mem_addr);
      end else begin
        mem_rd_data <= tbl.exists(mem_addr) ? tbl[mem_addr] : 32'd2;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Push a run of updates on consecutive cycles
  task automatic push_upd(input logic [31:0] a, input logic t, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      upd_vld = 1'b1; upd_addr = a; upd_taken = t;
    end
    @(negedge clk);
    upd_vld = 1'b0;
  endtask

  // Wait (bounded) until n writes have been logged, then check count
  task automatic wait_wr(input string tag, input int n);
    for (int i = 0; i < 40 && wq_data.size() < n; i++) @(negedge clk);
    chk(tag, 32'(wq_data.size()), 32'(n));
  endtask

  task automatic chk_wr(input string tag, input logic [31:0] a, input logic [31:0] d);
    if (wq_data.size() == 0) begin
      chk(tag, 32'hDEAD_DEAD, d);
    end else begin
      chk({tag, "_addr"}, wq_addr.pop_front(), a);
      chk({tag, "_data"}, wq_data.pop_front(), d);
    end
  endtask

  // Single lookup with FIFO empty: accepted at once, data next cycle
  task automatic lookup(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    lkp_vld = 1'b1; lkp_addr = a;
    #1 chk({tag, "_rdy"}, 32'(lkp_rdy), 32'd1);
    @(negedge clk);
    lkp_vld = 1'b0;
    #1 chk({tag, "_vld"}, 32'(lkp_rsp_vld), 32'd1);
    chk({tag, "_data"}, lkp_rsp_data, exp);
  endtask

  int grants;

  initial begin
    rst_n = 1'b0; lkp_vld = 1'b0; lkp_addr = '0;
    upd_vld = 1'b0; upd_addr = '0; upd_taken = 1'b0;
    cyc(3);
    #1;
    chk("rst_lkp_rdy", 32'(lkp_rdy), 32'd1);
    chk("rst_upd_rdy", 32'(upd_rdy), 32'd1);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_wr_data", mem_wr_data, 32'd0);
    chk("rst_rsp_vld", 32'(lkp_rsp_vld), 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // Fresh entry reads 2, taken -> 3, taken again saturates
    push_upd(32'h10, 1'b1, 1);
    wait_wr("fresh_n", 1);
    chk_wr("fresh_wr", 32'h10, 32'd3);
    lookup("fresh_lk", 32'h10, 32'd3);
    push_upd(32'h10, 1'b1, 1);
    wait_wr("sat_n", 1);
    chk_wr("sat_wr", 32'h10, 32'd3);
    lookup("sat_lk", 32'h10, 32'd3);

    // Decrement to floor: 2 -> 1 -> 0 -> 0
    push_upd(32'h20, 1'b0, 3);
    wait_wr("dec_n", 3);
    chk_wr("dec_wr0", 32'h20, 32'd1);
    chk_wr("dec_wr1", 32'h20, 32'd0);
    chk_wr("dec_wr2", 32'h20, 32'd0);
    lookup("dec_lk", 32'h20, 32'd0);

    // Upper bits survive the RMW
    tbl[32'h40] = 32'hABCD_0003;
    push_upd(32'h40, 1'b0, 1);
    wait_wr("upper_n", 1);
    chk_wr("upper_wr", 32'h40, 32'hABCD_0002);

    // Fill FIFO behind a lookup stream, then drain: 0 -> 1,2,3,3
    tbl[32'h30] = 32'd0;
    @(negedge clk);
    lkp_vld = 1'b1; lkp_addr = 32'h99;
    push_upd(32'h30, 1'b1, 4);
    #1 chk("full_upd_rdy", 32'(upd_rdy), 32'd0);
    lkp_vld = 1'b0;
    wait_wr("b2b_n", 4);
    chk_wr("b2b_wr0", 32'h30, 32'd1);
    chk_wr("b2b_wr1", 32'h30, 32'd2);
    chk_wr("b2b_wr2", 32'h30, 32'd3);
    chk_wr("b2b_wr3", 32'h30, 32'd3);
    cyc(1);
    #1 chk("drained_upd_rdy", 32'(upd_rdy), 32'd1);
    lookup("b2b_lk", 32'h30, 32'd3);

    // Starvation: constant lookups, one update queued
    @(negedge clk);
    lkp_vld = 1'b1; lkp_addr = 32'h50;
    upd_vld = 1'b1; upd_addr = 32'h55; upd_taken = 1'b1;
    @(negedge clk);
    upd_vld = 1'b0;
    grants = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (!lkp_rdy) break;
      grants++;
      @(negedge clk);
    end
    chk("starve_grants", 32'(grants), 32'd8);
    chk("starve_rd_en", 32'(mem_en), 32'd1);
    chk("starve_rd_we", 32'(mem_wr_en), 32'd0);
    chk("starve_rd_addr", mem_addr, 32'h55);
    @(negedge clk); #1;
    chk("starve_wr_rdy", 32'(lkp_rdy), 32'd0);
    chk("starve_wr_we", 32'(mem_wr_en), 32'd1);
    chk("starve_wr_rspv", 32'(lkp_rsp_vld), 32'd0);
    @(negedge clk); #1;
    chk("starve_resume_rdy", 32'(lkp_rdy), 32'd1);
    chk("starve_post_rspv", 32'(lkp_rsp_vld), 32'd0);
    lkp_vld = 1'b0;
    chk_wr("starve_wr", 32'h55, 32'd3);
    cyc(2);

    // Lookup streaming with the FIFO empty
    for (int i = 0; i < 16; i++) tbl[32'h100 + 32'(i)] = 32'h1000 + 32'(i);
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i < 16) begin
        lkp_vld = 1'b1; lkp_addr = 32'h100 + 32'(i);
      end else begin
        lkp_vld = 1'b0;
      end
      #1;
      if (i < 16) chk($sformatf("stream_rdy%0d", i), 32'(lkp_rdy), 32'd1);
      if (i >= 1) begin
        chk($sformatf("stream_vld%0d", i), 32'(lkp_rsp_vld), 32'd1);
        chk($sformatf("stream_data%0d", i), lkp_rsp_data, 32'h1000 + 32'(i - 1));
      end
    end
    @(negedge clk); #1;
    chk("stream_end_vld", 32'(lkp_rsp_vld), 32'd0);

    // Reset during UPD_WR drops the write and the queued update
    tbl[32'h60] = 32'd1;
    wq_data.delete(); wq_addr.delete();
    @(negedge clk);
    upd_vld = 1'b1; upd_addr = 32'h60; upd_taken = 1'b1;
    @(negedge clk);
    upd_addr = 32'h61;
    @(negedge clk);
    upd_vld = 1'b0;
    #1 chk("rstwr_pre_we", 32'(mem_wr_en), 32'd1);
    rst_n = 1'b0;
    #1 chk("rstwr_we", 32'(mem_wr_en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(10);
    #1;
    chk("rstwr_nwr", 32'(wq_data.size()), 32'd0);
    chk("rstwr_tbl", tbl[32'h60], 32'd1);
    chk("rstwr_mem_en", 32'(mem_en), 32'd0);
    chk("rstwr_upd_rdy", 32'(upd_rdy), 32'd1);
    chk("rstwr_rsp_vld", 32'(lkp_rsp_vld), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
